// File: rtl/variable_latency_bank_responder.sv
`default_nettype none
// ============================================================================
// Module      : variable_latency_bank_responder
// Description : Credit-based SRAM bank front end. Forwards granted requests
//               to the memory, tracks reads through a MemLatency-deep
//               pipeline and returns read data in order through a response
//               FIFO with a valid/ready handshake. Writes get no response.
//               Optional macro VARIABLE_LATENCY_BANK_RESP_FALLTHROUGH_EN lets
//               read data bypass an empty FIFO in the cycle it leaves the
//               pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module variable_latency_bank_responder #(
    parameter int NumIn        = 32,
    parameter int DataWidth    = 32,
    parameter int BeWidth      = DataWidth / 8,
    parameter int AddrMemWidth = 12,
    parameter int MemLatency   = 1,
    parameter int RespDepth    = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    // interconnect request
    input  logic                       req_i,
    output logic                       gnt_o,
    input  logic [$clog2(NumIn)-1:0]   ini_add_i,
    input  logic [AddrMemWidth-1:0]    add_i,
    input  logic                       wen_i,
    input  logic [DataWidth-1:0]       wdata_i,
    input  logic [BeWidth-1:0]         be_i,
    // interconnect response
    output logic                       vld_o,
    input  logic                       rdy_i,
    output logic [$clog2(NumIn)-1:0]   ini_add_o,
    output logic [DataWidth-1:0]       rdata_o,
    // memory
    output logic                       mem_req_o,
    output logic                       mem_we_o,
    output logic [AddrMemWidth-1:0]    mem_add_o,
    output logic [DataWidth-1:0]       mem_wdata_o,
    output logic [BeWidth-1:0]         mem_be_o,
    input  logic [DataWidth-1:0]       mem_rdata_i
);

    localparam int c_INI_W = $clog2(NumIn);
    localparam int c_CNT_W = $clog2(RespDepth + 1);
    localparam int c_PTR_W = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(RespDepth);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(RespDepth - 1);

    // credits: reads in flight plus occupied FIFO entries
    logic [c_CNT_W-1:0]   r_cnt;
    // read tracking pipeline
    logic [MemLatency-1:0] r_pipe_vld;
    logic [c_INI_W-1:0]   r_pipe_ini [0:MemLatency-1];
    // response FIFO
    logic [c_INI_W-1:0]   r_fifo_ini  [0:RespDepth-1];
    logic [DataWidth-1:0] r_fifo_data [0:RespDepth-1];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_CNT_W-1:0]   r_occ;

    logic w_accept;
    logic w_rd_accept;
    logic w_exit;
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_hs;

    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + c_PTR_W'(1);
    endfunction

    // Grant depends only on free credits; reset blocks acceptance outright
    assign gnt_o       = (r_cnt < c_DEPTH);
    assign w_accept    = req_i & gnt_o & ~rst_i;
    assign w_rd_accept = w_accept & ~wen_i;

    assign mem_req_o   = w_accept;
    assign mem_we_o    = w_accept & wen_i;
    assign mem_add_o   = add_i;
    assign mem_wdata_o = wdata_i;
    assign mem_be_o    = be_i;

    assign w_exit  = r_pipe_vld[MemLatency-1];
    assign w_empty = (r_occ == '0);
    assign w_full  = (r_occ == c_DEPTH);
    assign w_hs    = vld_o & rdy_i;

`ifdef VARIABLE_LATENCY_BANK_RESP_FALLTHROUGH_EN
    // Pipeline exit bypasses an empty FIFO; it is stored only if not taken
    assign vld_o     = ~w_empty | w_exit;
    assign ini_add_o = ~w_empty ? r_fifo_ini[r_rptr]
                     : (w_exit ? r_pipe_ini[MemLatency-1] : '0);
    assign rdata_o   = ~w_empty ? r_fifo_data[r_rptr]
                     : (w_exit ? mem_rdata_i : '0);
    assign w_push    = w_exit & ~(w_empty & rdy_i);
    assign w_pop     = ~w_empty & rdy_i;
`else
    // Responses come from the FIFO registers only
    assign vld_o     = ~w_empty;
    assign ini_add_o = w_empty ? '0 : r_fifo_ini[r_rptr];
    assign rdata_o   = w_empty ? '0 : r_fifo_data[r_rptr];
    assign w_push    = w_exit;
    assign w_pop     = ~w_empty & rdy_i;
`endif

    // Credit counter: +1 per accepted read, -1 per response handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_rd_accept && !w_hs) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end else if (!w_rd_accept && w_hs) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    // Read tracking shift pipeline aligned with the SRAM latency
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < MemLatency; i++) begin
                r_pipe_ini[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_rd_accept;
            r_pipe_ini[0] <= ini_add_i;
            for (int i = 1; i < MemLatency; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_ini[i] <= r_pipe_ini[i-1];
            end
        end
    end

    // FIFO storage; contents are masked on the outputs while empty
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_ini[r_wptr]  <= r_pipe_ini[MemLatency-1];
            r_fifo_data[r_wptr] <= mem_rdata_i;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= f_next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_next_ptr(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - c_CNT_W'(1);
            end
        end
    end

    // Credits make a push into a full FIFO unreachable
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(w_push && w_full));

endmodule
`default_nettype wire

// File: tb/tb_variable_latency_bank_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_variable_latency_bank_responder
// Description : Self-checking bench. Two responders (latency 1 / depth 2 and
//               latency 2 / depth 4) share one stimulus stream, each with its
//               own SRAM model and in-order response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_variable_latency_bank_responder;

`ifdef VARIABLE_LATENCY_BANK_RESP_FALLTHROUGH_EN
    localparam logic c_FT = 1'b1;
`else
    localparam logic c_FT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req;
    logic        wen;
    logic        rdy;
    logic [4:0]  ini_add;
    logic [11:0] add;
    logic [31:0] wdata;
    logic [3:0]  be;

    logic        gnt_a, vld_a, mem_req_a, mem_we_a;
    logic [4:0]  ini_add_a;
    logic [31:0] rdata_a, mem_wdata_a, mem_rdata_a;
    logic [11:0] mem_add_a;
    logic [3:0]  mem_be_a;

    logic        gnt_b, vld_b, mem_req_b, mem_we_b;
    logic [4:0]  ini_add_b;
    logic [31:0] rdata_b, mem_wdata_b, mem_rdata_b;
    logic [11:0] mem_add_b;
    logic [3:0]  mem_be_b;

    int n_chk  = 0;
    int n_fail = 0;
    int rsp_a  = 0;
    int rsp_b  = 0;

    typedef struct {
        logic [4:0]  ini;
        logic [31:0] data;
    } rsp_t;
    rsp_t q_a[$];
    rsp_t q_b[$];

    typedef struct {
        logic        req;
        logic        wen;
        logic [11:0] add;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_req;
        logic        exp_we;
    } vec_t;
    vec_t vt[7];

    logic [11:0] tp_addr[8];
    logic [31:0] shadow[4096];
    logic [31:0] sram_a[4096];
    logic [31:0] sram_b[4096];
    logic [31:0] rd_a, rd_b0, rd_b1;

    variable_latency_bank_responder #(
        .NumIn(32), .DataWidth(32), .BeWidth(4), .AddrMemWidth(12),
        .MemLatency(1), .RespDepth(2)
    ) dut_a (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .gnt_o(gnt_a), .ini_add_i(ini_add), .add_i(add),
        .wen_i(wen), .wdata_i(wdata), .be_i(be),
        .vld_o(vld_a), .rdy_i(rdy), .ini_add_o(ini_add_a), .rdata_o(rdata_a),
        .mem_req_o(mem_req_a), .mem_we_o(mem_we_a), .mem_add_o(mem_add_a),
        .mem_wdata_o(mem_wdata_a), .mem_be_o(mem_be_a), .mem_rdata_i(mem_rdata_a)
    );

    variable_latency_bank_responder #(
        .NumIn(32), .DataWidth(32), .BeWidth(4), .AddrMemWidth(12),
        .MemLatency(2), .RespDepth(4)
    ) dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .gnt_o(gnt_b), .ini_add_i(ini_add), .add_i(add),
        .wen_i(wen), .wdata_i(wdata), .be_i(be),
        .vld_o(vld_b), .rdy_i(rdy), .ini_add_o(ini_add_b), .rdata_o(rdata_b),
        .mem_req_o(mem_req_b), .mem_we_o(mem_we_b), .mem_add_o(mem_add_b),
        .mem_wdata_o(mem_wdata_b), .mem_be_o(mem_be_b), .mem_rdata_i(mem_rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models: byte-enabled writes, reads valid exactly MemLatency later
    always @(posedge clk) begin
        if (mem_req_a && mem_we_a) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_a[b]) sram_a[mem_add_a][8*b +: 8] <= mem_wdata_a[8*b +: 8];
            end
        end
        if (mem_req_b && mem_we_b) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_b[b]) sram_b[mem_add_b][8*b +: 8] <= mem_wdata_b[8*b +: 8];
            end
        end
        rd_a  <= (mem_req_a && !mem_we_a) ? sram_a[mem_add_a] : 32'hDEADBEEF;
        rd_b0 <= (mem_req_b && !mem_we_b) ? sram_b[mem_add_b] : 32'hDEADBEEF;
        rd_b1 <= rd_b0;
    end
    assign mem_rdata_a = rd_a;
    assign mem_rdata_b = rd_b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic shadow_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] m);
        for (int b = 0; b < 4; b++) begin
            if (m[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic drain();
        @(posedge clk); #1;
        req = 1'b0;
        rdy = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    // Scoreboards: expect on accepted read, compare head while valid, pop on handshake
    always @(negedge clk) begin
        if (rst) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (vld_a) begin
                if (q_a.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL sb_a_unexpected: got ini %0h data %0h required none", ini_add_a, rdata_a);
                end else begin
                    chk("sb_a_ini", ini_add_a, q_a[0].ini);
                    chk("sb_a_data", rdata_a, q_a[0].data);
                    if (rdy) begin
                        void'(q_a.pop_front());
                        rsp_a++;
                    end
                end
            end
            if (vld_b) begin
                if (q_b.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL sb_b_unexpected: got ini %0h data %0h required none", ini_add_b, rdata_b);
                end else begin
                    chk("sb_b_ini", ini_add_b, q_b[0].ini);
                    chk("sb_b_data", rdata_b, q_b[0].data);
                    if (rdy) begin
                        void'(q_b.pop_front());
                        rsp_b++;
                    end
                end
            end
            if (req && !wen && gnt_a) q_a.push_back('{ini: ini_add, data: shadow[add]});
            if (req && !wen && gnt_b) q_b.push_back('{ini: ini_add, data: shadow[add]});
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1);
    end

    initial begin
        logic [4:0]  i1, i2;
        logic [31:0] d1, d2;
        logic        v1, v2;
        int          k, guard, rsp_b0;
        logic        acc;

        vt[0] = '{1'b1, 1'b1, 12'h010, 32'hCAFEF00D, 4'hF, 1'b1, 1'b1};
        vt[1] = '{1'b1, 1'b1, 12'h011, 32'h11111111, 4'hF, 1'b1, 1'b1};
        vt[2] = '{1'b1, 1'b1, 12'h012, 32'h22222222, 4'hF, 1'b1, 1'b1};
        vt[3] = '{1'b0, 1'b1, 12'h013, 32'h33333333, 4'hF, 1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b1, 12'h3FF, 32'hA5A5A5A5, 4'h5, 1'b1, 1'b1};
        vt[5] = '{1'b0, 1'b0, 12'h000, 32'h0BADF00D, 4'hF, 1'b0, 1'b0};
        vt[6] = '{1'b1, 1'b1, 12'hFFF, 32'h12345678, 4'h8, 1'b1, 1'b1};
        tp_addr = '{12'h010, 12'h011, 12'h012, 12'h013, 12'h3FF, 12'hFFF, 12'h000, 12'h020};
        for (int i = 0; i < 4096; i++) begin
            shadow[i] = '0; sram_a[i] = '0; sram_b[i] = '0;
        end

        // Reset: memory request suppressed even with req high
        rst = 1'b1; req = 1'b1; wen = 1'b0; rdy = 1'b1;
        ini_add = '0; add = '0; wdata = '0; be = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req_a", mem_req_a, 0);
        chk("rst_mem_req_b", mem_req_b, 0);
        chk("rst_vld_a", vld_a, 0);
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_gnt_a", gnt_a, 1);
        chk("rel_gnt_b", gnt_b, 1);
        chk("rel_vld_b", vld_b, 0);
        chk("rel_ini_a", ini_add_a, 0);
        chk("rel_rdata_a", rdata_a, 0);

        // Request forwarding table
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            req = vt[i].req; wen = vt[i].wen; add = vt[i].add;
            wdata = vt[i].wdata; be = vt[i].be; ini_add = 5'(i);
            if (vt[i].req && vt[i].wen) shadow_wr(vt[i].add, vt[i].wdata, vt[i].be);
            @(negedge clk);
            chk($sformatf("vec%0d_mem_req_a", i), mem_req_a, vt[i].exp_req);
            chk($sformatf("vec%0d_mem_req_b", i), mem_req_b, vt[i].exp_req);
            chk($sformatf("vec%0d_vld_a", i), vld_a, 0);
            if (vt[i].req) begin
                chk($sformatf("vec%0d_mem_we", i), mem_we_a, vt[i].exp_we);
                chk($sformatf("vec%0d_mem_add", i), mem_add_a, vt[i].add);
                chk($sformatf("vec%0d_mem_wdata", i), mem_wdata_a, vt[i].wdata);
                chk($sformatf("vec%0d_mem_be", i), mem_be_a, vt[i].be);
                chk($sformatf("vec%0d_gnt", i), gnt_a, 1);
            end
        end
        drain();

        // Single read latency on the latency-1 responder
        req = 1'b1; wen = 1'b0; ini_add = 5'd5; add = 12'h010;
        @(negedge clk);
        chk("r27_gnt", gnt_a, 1);
        chk("r27_mem_we", mem_we_a, 0);
        chk("r27_mem_add", mem_add_a, 12'h010);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        v1 = vld_a; i1 = ini_add_a; d1 = rdata_a;
        @(negedge clk);
        v2 = vld_a; i2 = ini_add_a; d2 = rdata_a;
        chk("r27_vld_t1", v1, c_FT);
        chk("r27_vld_t2", v2, !c_FT);
        chk("r27_ini", c_FT ? i1 : i2, 5);
        chk("r27_rdata", c_FT ? d1 : d2, 32'hCAFEF00D);
        @(negedge clk);
        chk("r27_cnt", dut_a.r_cnt, 0);
        drain();

        // Writes only under back-pressure: no responses, no credits used
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req = 1'b1; wen = 1'b1; ini_add = 5'(i); add = 12'h020 + 12'(i);
            wdata = 32'hA5000000 + 32'(i) * 32'h01010101;
            be = (i % 2 == 1) ? 4'b0011 : 4'b1111;
            shadow_wr(add, wdata, be);
            @(negedge clk);
            chk($sformatf("r29_gnt%0d", i), gnt_a, 1);
            chk($sformatf("r29_we%0d", i), mem_we_a, 1);
            chk($sformatf("r29_vld%0d", i), vld_a, 0);
            @(posedge clk); #1;
        end
        req = 1'b0;
        @(negedge clk);
        chk("r29_cnt_a", dut_a.r_cnt, 0);
        chk("r29_cnt_b", dut_b.r_cnt, 0);
        drain();

        // Back-to-back reads at full rate on the latency-2 / depth-4 responder
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req = 1'b1; wen = 1'b0; ini_add = 5'(i + 8); add = tp_addr[i];
            @(negedge clk);
            chk($sformatf("r20_gnt_b%0d", i), gnt_b, 1);
            @(posedge clk); #1;
        end
        req = 1'b0;
        drain();

        // Back-pressure on the depth-2 responder
        rdy = 1'b0; req = 1'b1; wen = 1'b0; ini_add = 5'd1; add = 12'h010;
        @(negedge clk);
        chk("r28_gnt1", gnt_a, 1);
        @(posedge clk); #1;
        ini_add = 5'd2; add = 12'h011;
        @(negedge clk);
        chk("r28_gnt2", gnt_a, 1);
        @(posedge clk); #1;
        ini_add = 5'd3; add = 12'h012;
        @(negedge clk);
        chk("r28_gnt3_blocked", gnt_a, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("r28_gnt3_still_blocked", gnt_a, 0);
        chk("r28_vld", vld_a, 1);
        chk("r28_head", ini_add_a, 1);
        @(posedge clk); #1;
        rdy = 1'b1;
        @(negedge clk);
        chk("r28_gnt_at_hs", gnt_a, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("r28_gnt_after_hs", gnt_a, 1);
        chk("r28_head2", ini_add_a, 2);
        @(posedge clk); #1;
        req = 1'b0;
        drain();

        // Streaming with rdy toggling on the latency-2 / depth-4 responder
        rsp_b0 = rsp_b;
        k = 0; guard = 0;
        rdy = 1'b1; req = 1'b1; wen = 1'b0; ini_add = 5'd0; add = 12'h020;
        while (k < 20 && guard < 400) begin
            @(negedge clk);
            acc = gnt_b;
            @(posedge clk); #1;
            rdy = ~rdy;
            guard++;
            if (acc) begin
                k++;
                ini_add = 5'(k);
                add = 12'h020 + 12'(k);
            end
            if (k == 20) req = 1'b0;
        end
        req = 1'b0;
        chk("r30_issued", k, 20);
        drain();
        chk("r30_responses", rsp_b - rsp_b0, 20);
        chk("r30_sb_empty", q_b.size(), 0);

        // Reset with two reads in flight and one queued
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req = 1'b1; wen = 1'b0; ini_add = 5'(20 + i); add = 12'h020 + 12'(i);
            @(posedge clk); #1;
        end
        chk("r31_pre_vld_b", vld_b, 1);
        chk("r31_pre_cnt_b", dut_b.r_cnt, 3);
        rst = 1'b1;
        #1;
        chk("r31_vld_b", vld_b, 0);
        chk("r31_vld_a", vld_a, 0);
        chk("r31_mem_req_b", mem_req_b, 0);
        chk("r31_mem_req_a", mem_req_a, 0);
        chk("r31_ini_b", ini_add_b, 0);
        chk("r31_rdata_b", rdata_b, 0);
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0; rdy = 1'b1;
        @(negedge clk);
        chk("r31_gnt_a", gnt_a, 1);
        chk("r31_gnt_b", gnt_b, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("r31_stale_a%0d", i), vld_a, 0);
            chk($sformatf("r31_stale_b%0d", i), vld_b, 0);
        end
        chk("end_sb_a_empty", q_a.size(), 0);
        chk("end_sb_b_empty", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
